// File: rtl/data_path.sv
// data_path: 32-bit single-bus CPU datapath.
// Sixteen-entry register file (R0 hard-wired to zero), PC, IR, MAR, MDR, Y,
// 64-bit Z, HI and LO around a priority bus multiplexer and a 64-bit ALU.
// Optional feature macro: DATAPATH_MUL_EN enables the signed 32x32->64
// multiply on opcode 01111; without it that opcode yields zero.
module data_path (
  input  logic        PCout,
  input  logic        ZHighout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        MARin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        IncPC,
  input  logic        Read,
  input  logic [4:0]  OR,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        R4in,
  input  logic        R5in,
  input  logic        R6in,
  input  logic        R7in,
  input  logic        R8in,
  input  logic        R9in,
  input  logic        R10in,
  input  logic        R11in,
  input  logic        R12in,
  input  logic        R13in,
  input  logic        R14in,
  input  logic        R15in,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        ZHighIn,
  input  logic        ZLowIn,
  input  logic        Cin,
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] Mdatain,
  output logic [31:0] BusMuxOut,
  output logic [31:0] IRq,
  output logic [31:0] MARq
);

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00011,
    ALU_SUB  = 5'b00100,
    ALU_SHR  = 5'b00101,
    ALU_SHRA = 5'b00110,
    ALU_SHL  = 5'b00111,
    ALU_ROR  = 5'b01000,
    ALU_ROL  = 5'b01001,
    ALU_AND  = 5'b01010,
    ALU_OR   = 5'b01011,
    ALU_NEG  = 5'b01100,
    ALU_NOT  = 5'b01101,
    ALU_MUL  = 5'b01111
  } alu_op_e;

  // Architectural registers. R0 is never loadable and always reads zero,
  // so only R1..R15 carry storage.
  logic [31:0] pc_q,  pc_d;
  logic [31:0] ir_q,  ir_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] y_q,   y_d;
  logic [63:0] z_q,   z_d;
  logic [31:0] hi_q,  hi_d;
  logic [31:0] lo_q,  lo_d;
  logic [31:0] rf_q [1:15];
  logic [31:0] rf_d [1:15];

  logic [15:1] r_in;
  logic [31:0] bus;
  logic [63:0] alu_c;
  alu_op_e     alu_op;

  assign r_in   = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in};
  assign alu_op = alu_op_e'(OR);

  // Bus multiplexer: fixed-priority source select, zero when idle.
  always_comb begin
    bus = '0;
    if (PCout)         bus = pc_q;
    else if (MDRout)   bus = mdr_q;
    else if (Zlowout)  bus = z_q[31:0];
    else if (ZHighout) bus = z_q[63:32];
    else if (R2out)    bus = rf_q[2];
    else if (R3out)    bus = rf_q[3];
  end

  assign BusMuxOut = bus;
  assign IRq       = ir_q;
  assign MARq      = mar_q;

  // ALU operand helpers: A = Y, B = bus, shift/rotate amount = B[4:0].
  logic [4:0]         shamt;
  logic signed [31:0] a_signed;
  logic [63:0]        a_dbl;
  logic [31:0]        sum32;

  assign shamt    = bus[4:0];
  assign a_signed = y_q;
  assign a_dbl    = {y_q, y_q};
  assign sum32    = y_q + bus + {31'd0, Cin};

`ifdef DATAPATH_MUL_EN
  logic signed [63:0] mul_p;
  assign mul_p = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});
`endif

  // ALU: 64-bit result, upper half zero except for multiply.
  always_comb begin
    alu_c = '0;
    unique case (alu_op)
      ALU_ADD:  alu_c[31:0] = sum32;
      ALU_SUB:  alu_c[31:0] = y_q - bus;
      ALU_SHR:  alu_c[31:0] = y_q >> shamt;
      ALU_SHRA: alu_c[31:0] = a_signed >>> shamt;
      ALU_SHL:  alu_c[31:0] = y_q << shamt;
      // Rotates shift a doubled copy of A and keep the relevant 32-bit window.
      ALU_ROR:  alu_c[31:0] = 32'(a_dbl >> shamt);
      ALU_ROL:  alu_c[31:0] = a_dbl[63:32] << shamt | a_dbl[31:0] >> (6'd32 - {1'b0, shamt});
      ALU_AND:  alu_c[31:0] = y_q & bus;
      ALU_OR:   alu_c[31:0] = y_q | bus;
      ALU_NEG:  alu_c[31:0] = '0 - bus;
      ALU_NOT:  alu_c[31:0] = ~bus;
`ifdef DATAPATH_MUL_EN
      ALU_MUL:  alu_c = mul_p;
`endif
      default:  alu_c = '0;
    endcase
  end

  // Next-state for bus-loaded registers, MDR, PC and the split Z register.
  always_comb begin
    ir_d  = IRin  ? bus : ir_q;
    mar_d = MARin ? bus : mar_q;
    y_d   = Yin   ? bus : y_q;
    hi_d  = HIin  ? bus : hi_q;
    lo_d  = LOin  ? bus : lo_q;
    mdr_d = mdr_q;
    if (MDRin) mdr_d = Read ? Mdatain : bus;
    pc_d = pc_q;
    if (IncPC)     pc_d = pc_q + 32'd1;
    else if (PCin) pc_d = bus;
    z_d = z_q;
    if (ZLowIn)  z_d[31:0]  = alu_c[31:0];
    if (ZHighIn) z_d[63:32] = alu_c[63:32];
    for (int unsigned i = 1; i <= 15; i++) begin
      rf_d[i] = r_in[i] ? bus : rf_q[i];
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      for (int unsigned i = 1; i <= 15; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      z_q   <= z_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      for (int unsigned i = 1; i <= 15; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed test-plan sequences followed by randomized control
// strobes, all compared against a behavioural model of the datapath.
module tb_data_path;

  logic        PCout, ZHighout, Zlowout, MDRout, R2out, R3out;
  logic        MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic [4:0]  op;
  logic [15:1] rin;
  logic        HIin, LOin, ZHighIn, ZLowIn, Cin;
  logic        Clock, Clear;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut, IRq, MARq;

  data_path dut (
    .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .R2out(R2out), .R3out(R3out), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read), .OR(op),
    .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]), .R4in(rin[4]), .R5in(rin[5]),
    .R6in(rin[6]), .R7in(rin[7]), .R8in(rin[8]), .R9in(rin[9]),
    .R10in(rin[10]), .R11in(rin[11]), .R12in(rin[12]), .R13in(rin[13]),
    .R14in(rin[14]), .R15in(rin[15]), .HIin(HIin), .LOin(LOin),
    .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Cin(Cin), .Clock(Clock),
    .Clear(Clear), .Mdatain(Mdatain), .BusMuxOut(BusMuxOut), .IRq(IRq),
    .MARq(MARq)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] last_bus;

  // Reference state.
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo;
  logic [63:0] m_z;
  logic [31:0] m_r [1:15];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0; m_hi = 0; m_lo = 0; m_z = 0;
    for (int i = 1; i <= 15; i++) m_r[i] = 0;
  endtask

  function automatic logic [31:0] model_bus();
    if (PCout)    return m_pc;
    if (MDRout)   return m_mdr;
    if (Zlowout)  return m_z[31:0];
    if (ZHighout) return m_z[63:32];
    if (R2out)    return m_r[2];
    if (R3out)    return m_r[3];
    return 32'h0;
  endfunction

  function automatic logic [63:0] alu_ref(input logic [4:0] code, input logic [31:0] a,
                                          input logic [31:0] b, input logic ci);
    logic [31:0] r;
    int          s;
    longint      p;
    s = int'(b[4:0]);
    case (code)
      5'd3:  r = a + b + 32'(ci);
      5'd4:  r = a - b;
      5'd5:  r = a >> s;
      5'd6: begin
        r = a >> s;
        if (a[31]) for (int k = 0; k < s; k++) r[31-k] = 1'b1;
      end
      5'd7:  r = a << s;
      5'd8: begin r = a; repeat (s) r = {r[0], r[31:1]}; end
      5'd9: begin r = a; repeat (s) r = {r[30:0], r[31]}; end
      5'd10: r = a & b;
      5'd11: r = a | b;
      5'd12: r = ~b + 32'd1;
      5'd13: r = ~b;
      5'd15: begin
`ifdef DATAPATH_MUL_EN
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
`else
        p = 0;
        return p;
`endif
      end
      default: r = 32'h0;
    endcase
    return {32'h0, r};
  endfunction

  task automatic model_commit();
    logic [31:0] b;
    logic [63:0] c;
    b = model_bus();
    c = alu_ref(op, m_y, b, Cin);
    for (int i = 1; i <= 15; i++) if (rin[i]) m_r[i] = b;
    if (Yin)   m_y   = b;
    if (IRin)  m_ir  = b;
    if (MARin) m_mar = b;
    if (HIin)  m_hi  = b;
    if (LOin)  m_lo  = b;
    if (MDRin) m_mdr = Read ? Mdatain : b;
    if (IncPC)     m_pc = m_pc + 32'd1;
    else if (PCin) m_pc = b;
    if (ZLowIn)  m_z[31:0]  = c[31:0];
    if (ZHighIn) m_z[63:32] = c[63:32];
  endtask

  task automatic idle();
    PCout = 0; ZHighout = 0; Zlowout = 0; MDRout = 0; R2out = 0; R3out = 0;
    MARin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0; IncPC = 0; Read = 0;
    op = 5'd0; rin = '0; HIin = 0; LOin = 0; ZHighIn = 0; ZLowIn = 0; Cin = 0;
  endtask

  // Called just after a rising edge with controls already driven.
  task automatic cycle();
    #2;
    last_bus = BusMuxOut;
    check_val("bus", BusMuxOut, model_bus());
    model_commit();
    @(posedge Clock);
    #1;
    check_val("irq", IRq, m_ir);
    check_val("marq", MARq, m_mar);
  endtask

  task automatic load_mdr(input logic [31:0] v);
    idle(); Read = 1; MDRin = 1; Mdatain = v; cycle();
  endtask

  task automatic clear_pulse();
    idle();
    #1 Clear = 1;
    #1 check_val("clr_bus_idle", BusMuxOut, 0);
    check_val("clr_irq", IRq, 0);
    check_val("clr_marq", MARq, 0);
    PCout = 1;  #1 check_val("clr_pc", BusMuxOut, 0);
    PCout = 0; MDRout = 1; #0 check_val("clr_mdr", BusMuxOut, 0);
    MDRout = 0; Zlowout = 1; #0 check_val("clr_zlo", BusMuxOut, 0);
    Zlowout = 0; R2out = 1; #0 check_val("clr_r2", BusMuxOut, 0);
    R2out = 0;
    Clear = 0;
    model_reset();
    check_val("clr_r1", dut.rf_q[1], 0);
    @(posedge Clock);
    #1;
  endtask

  int valid_ops [12] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 15};

  initial begin
    idle();
    Mdatain = 0;
    Clear = 1;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    check_val("rst_bus", BusMuxOut, 0);
    check_val("rst_irq", IRq, 0);
    check_val("rst_marq", MARq, 0);
    Clear = 0;

    // Register loads through MDR.
    load_mdr(32'h12); idle(); MDRout = 1; rin[2] = 1; cycle();
    load_mdr(32'h14); idle(); MDRout = 1; rin[3] = 1; cycle();
    load_mdr(32'h18); idle(); MDRout = 1; rin[1] = 1; cycle();
    check_val("r1_ld", dut.rf_q[1], 32'h18);

    // OR: R1 <- R2 | R3.
    idle(); R2out = 1; Yin = 1; cycle();
    check_val("r2_ld", last_bus, 32'h12);
    idle(); R3out = 1; op = 5'b01011; ZLowIn = 1; cycle();
    check_val("r3_ld", last_bus, 32'h14);
    idle(); Zlowout = 1; rin[1] = 1; cycle();
    check_val("or_z", last_bus, 32'h16);
    check_val("or_r1", dut.rf_q[1], 32'h16);

    // Fetch.
    load_mdr(32'd7); idle(); MDRout = 1; PCin = 1; cycle();
    idle(); PCout = 1; MARin = 1; IncPC = 1; PCin = 1; cycle();
    check_val("pc7", last_bus, 32'd7);
    check_val("mar7", MARq, 32'd7);
    idle(); PCout = 1; cycle();
    check_val("pc8", last_bus, 32'd8);
    load_mdr(32'h28918000); idle(); MDRout = 1; IRin = 1; cycle();
    check_val("ir_fetch", IRq, 32'h28918000);

    // ADD with carry wrapping to zero.
    load_mdr(32'hFFFFFFFF); idle(); MDRout = 1; Yin = 1; cycle();
    idle(); op = 5'b00011; Cin = 1; ZLowIn = 1; ZHighIn = 1; cycle();
    idle(); Zlowout = 1; cycle();
    check_val("add_lo", last_bus, 0);
    idle(); ZHighout = 1; cycle();
    check_val("add_hi", last_bus, 0);

    // Preload Z low with ~0 so the multiply result is distinguishable.
    idle(); op = 5'b01101; ZLowIn = 1; cycle();
    load_mdr(32'd2); idle(); MDRout = 1; Yin = 1; cycle();
    load_mdr(32'hFFFFFFFD); idle(); MDRout = 1; op = 5'b01111; ZHighIn = 1; ZLowIn = 1; cycle();
    idle(); Zlowout = 1; cycle();
`ifdef DATAPATH_MUL_EN
    check_val("mul_lo", last_bus, 32'hFFFFFFFA);
`else
    check_val("mul_lo", last_bus, 32'h0);
`endif
    idle(); ZHighout = 1; cycle();
`ifdef DATAPATH_MUL_EN
    check_val("mul_hi", last_bus, 32'hFFFFFFFF);
`else
    check_val("mul_hi", last_bus, 32'h0);
`endif

    clear_pulse();

    // Randomized control sequences.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 59) == 0) clear_pulse();
      idle();
      PCout    = ($urandom_range(0, 5) == 0);
      MDRout   = ($urandom_range(0, 3) == 0);
      Zlowout  = ($urandom_range(0, 3) == 0);
      ZHighout = ($urandom_range(0, 3) == 0);
      R2out    = ($urandom_range(0, 2) == 0);
      R3out    = ($urandom_range(0, 2) == 0);
      MARin    = ($urandom_range(0, 3) == 0);
      PCin     = ($urandom_range(0, 3) == 0);
      MDRin    = ($urandom_range(0, 1) == 0);
      IRin     = ($urandom_range(0, 3) == 0);
      Yin      = ($urandom_range(0, 2) == 0);
      IncPC    = ($urandom_range(0, 4) == 0);
      Read     = ($urandom_range(0, 1) == 0);
      HIin     = ($urandom_range(0, 3) == 0);
      LOin     = ($urandom_range(0, 3) == 0);
      ZLowIn   = ($urandom_range(0, 1) == 0);
      ZHighIn  = ($urandom_range(0, 1) == 0);
      Cin      = ($urandom_range(0, 1) == 0);
      for (int i = 1; i <= 15; i++) rin[i] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) op = 5'(valid_ops[$urandom_range(0, 11)]);
      else                           op = 5'($urandom_range(0, 31));
      Mdatain = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_path.md
# data_path

32-bit single-bus CPU datapath: sixteen-entry register file (R1–R15 loadable), PC, IR, MAR, MDR, Y, 64-bit Z, HI and LO registers around a combinational bus multiplexer and ALU. An external control unit or testbench sequences it cycle by cycle with discrete register-in/register-out strobes and a 5-bit ALU opcode. Memory read data enters through Mdatain into MDR.

## Interface
- No parameters.
- Clock  in  1  rising-edge clock for all registers.
- Clear  in  1  asynchronous, active-high reset; zeroes every register.
- Positional port order (binding): PCout, ZHighout, Zlowout, MDRout, R2out, R3out, MARin, PCin, MDRin, IRin, Yin, IncPC, Read, OR, R1in–R15in, HIin, LOin, ZHighIn, ZLowIn, Cin, Clock, Clear, Mdatain, BusMuxOut, IRq, MARq.
- PCout, ZHighout, Zlowout, MDRout, R2out, R3out  in  1 each  bus-source selects.
- MARin, PCin, MDRin, IRin, Yin, R1in–R15in, HIin, LOin, ZHighIn, ZLowIn  in  1 each  register load enables.
- IncPC  in  1  PC increment.
- Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
- OR  in  5  ALU opcode.
- Cin  in  1  carry-in for ADD.
- Mdatain  in  32  memory read data.
- BusMuxOut  out  32  current bus value.
- IRq  out  32  IR contents.
- MARq  out  32  MAR contents.

## Operation
- Bus source priority: PCout > MDRout > Zlowout > ZHighout > R2out > R3out. With no source asserted, the bus is 0.
- ALU inputs: A = Y, B = bus. It produces a 64-bit result C; unlisted operations leave C[63:32] = 0.
- ALU opcodes:
  - 00011 ADD: A+B+Cin.
  - 00100 SUB: A−B.
  - 00101 SHR: logical, by B[4:0].
  - 00110 SHRA: arithmetic.
  - 00111 SHL.
  - 01000 ROR.
  - 01001 ROL.
  - 01010 AND.
  - 01011 OR.
  - 01100 NEG: −B.
  - 01101 NOT: ~B.
  - 01111 MUL: signed A×B, full 64 bits.
  - Any other code: C = 0.
- Z loads: ZLowIn loads Z[31:0] ← C[31:0]; ZHighIn loads Z[63:32] ← C[63:32]. They are independent.
- Bus-loaded registers: Rn, Y, IR, MAR, HI and LO load from the bus when their enable is high.
- R0 exists but is not loadable and reads as 0.
- MDR loads on MDRin from the Read mux.
- PC update:
  - IncPC=1: PC ← PC+1, wrapping at 2^32. IncPC overrides PCin.
  - Else PCin=1: PC ← bus.
- Multiple load enables in one cycle all load the same bus value.

## Timing
- All register updates happen on the rising edge of Clock. Bus, ALU and the outputs are combinational from register state.
- Latencies:
  - Register-to-register transfer: 1 cycle.
  - ALU operation (Y load, Z load, Z writeback): 3 cycles.
  - Memory load (Mdatain → MDR, MDR → Rn): 2 cycles.
- Clear asserted at any time zeroes every register and Z immediately. BusMuxOut, IRq and MARq read 0 while Clear is high. Loads resume on the first rising edge after Clear falls.
- Clear has priority over all enables in the same edge.

## Configuration
- DATAPATH_MUL_EN:
  - Defined: opcode 01111 performs the 64-bit signed multiply.
  - Undefined: 01111 yields C = 0 and no multiplier is synthesized.

## Test plan
- Reset: pulse Clear mid-run → PC, IR, MAR, MDR, R1–R15 and Z read 0; BusMuxOut = 0 with no source selected.
- Register load via MDR:
  - Mdatain=0x12, Read+MDRin, then MDRout+R2in → R2=0x12.
  - Likewise R3=0x14 and R1=0x18.
- OR: R2out+Yin, then R3out+OR=01011+ZLowIn, then Zlowout+R1in → R1=0x16.
- Fetch:
  - Mdatain=7, MDRout+PCin → PC=7.
  - PCout+MARin+IncPC → MAR=7, PC=8.
  - Read+MDRin with Mdatain=0x28918000, then MDRout+IRin → IRq=0x28918000.
- ADD with carry: Y=0xFFFFFFFF, B=0, Cin=1 → Z[31:0]=0.
- MUL (macro defined): Y=0x00000002, B=0xFFFFFFFD → Z=0xFFFFFFFFFFFFFFFA via ZHighIn+ZLowIn.
- MUL (macro undefined): same inputs → Z=0.
